led_count_sequencer: RTL

//   Parametrised Moore-FSM tick counter. Generalises the fixed 4-bit LED counter with WIDTH/MAX_COUNT, pause, auto-repeat and done hold time.
//   An internal prescaler produces a clock-enable tick; there is no derived clock. Board top drives count_out/done to the LED bank.

---
 rtl/led_count_sequencer_if.sv | 29 ++
 rtl/led_count_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_count_sequencer_if.sv
// Handshake bundle for led_count_sequencer: control requests in, count/status out.
// Signal directions are named from the sequencer's point of view (i_ = into it).
// Optional feature macro: DOWN_COUNT_EN adds the i_dir request.
interface led_count_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             i_go;
  logic             i_stop;
  logic             i_repeat;
`ifdef DOWN_COUNT_EN
  logic             i_dir;
`endif
  logic [WIDTH-1:0] o_count;
  logic             o_tick;
  logic             o_busy;
  logic             o_done;

`ifdef DOWN_COUNT_EN
  modport master (output i_go, i_stop, i_repeat, i_dir,
                  input  o_count, o_tick, o_busy, o_done);
  modport slave  (input  i_go, i_stop, i_repeat, i_dir,
                  output o_count, o_tick, o_busy, o_done);
`else
  modport master (output i_go, i_stop, i_repeat,
                  input  o_count, o_tick, o_busy, o_done);
  modport slave  (input  i_go, i_stop, i_repeat,
                  output o_count, o_tick, o_busy, o_done);
`endif
endinterface

// File: rtl/led_count_sequencer.sv
// Parametrised Moore tick counter driving an LED bank.
// A prescaler divides i_clk30 by DIV = CLK_HZ/TICK_HZ into a clock-enable tick;
// each tick advances the count until MAX_COUNT, then DONE is held for
// DONE_TICKS ticks before returning to IDLE or (repeat) restarting the count.
// Optional feature macro: DOWN_COUNT_EN adds a direction request latched at
// start; when set the count runs MAX_COUNT down to 0.
// The interface WIDTH parameter must match this module's WIDTH.
module led_count_sequencer #(
  parameter int CLK_HZ     = 30000000,
  parameter int TICK_HZ    = 4,
  parameter int WIDTH      = 4,
  parameter int MAX_COUNT  = 2**WIDTH - 1,
  parameter int DONE_TICKS = 1
) (
  input  logic                  i_clk30,
  input  logic                  i_rst,
  led_count_sequencer_if.slave  bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV + 1);
  localparam int DW  = $clog2(DONE_TICKS + 1);

  localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
  localparam logic [DW-1:0]    DONE_LAST = DW'(DONE_TICKS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_pre;
  logic [DW-1:0]    r_done_cnt;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_wrap;
  logic             w_down;
  logic             w_at_end;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_entry_val;
  logic [WIDTH-1:0] w_reload;

`ifdef DOWN_COUNT_EN
  logic r_dir;
  assign w_down      = r_dir;
  // Start value uses the live request because r_dir is captured on the same edge.
  assign w_entry_val = bus.i_dir ? MAX_VAL : '0;
`else
  assign w_down      = 1'b0;
  assign w_entry_val = '0;
`endif

  // Stop outranks go everywhere; the prescaler wraps on its last count.
  assign w_accept = bus.i_go && !bus.i_stop;
  assign w_wrap   = (r_pre == PRE_LAST);
  assign w_at_end = w_down ? (r_count == '0) : (r_count == MAX_VAL);
  assign w_step   = w_down ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
  assign w_reload = w_down ? MAX_VAL : '0;

  // Single-process FSM: state, prescaler, count and registered outputs.
  always_ff @(posedge i_clk30) begin
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_done_cnt <= '0;
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DOWN_COUNT_EN
      r_dir      <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pre      <= '0;
          r_done_cnt <= '0;
          r_count    <= '0;
          if (w_accept) begin
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
            r_count <= w_entry_val;
`ifdef DOWN_COUNT_EN
            r_dir   <= bus.i_dir;
`endif
          end
        end
        S_COUNT: begin
          if (bus.i_stop) begin
            // Count and prescaler freeze; a coincident tick is dropped.
            r_state <= S_PAUSE;
          end else if (w_wrap) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            if (w_at_end) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_done_cnt <= '0;
            end else begin
              r_count <= w_step;
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end
        S_PAUSE: begin
          if (w_accept) begin
            r_state <= S_COUNT;
          end
        end
        S_DONE: begin
          if (w_wrap) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            if (r_done_cnt == DONE_LAST) begin
              r_done     <= 1'b0;
              r_done_cnt <= '0;
              if (bus.i_repeat) begin
                r_state <= S_COUNT;
                r_count <= w_reload;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_count <= '0;
              end
            end else begin
              r_done_cnt <= r_done_cnt + DW'(1);
            end
          end else begin
            r_pre <= r_pre + PW'(1);
          end
        end
        default: begin
          // NOTE: an unreachable encoding recovers to a clean IDLE.
          r_state    <= S_IDLE;
          r_pre      <= '0;
          r_done_cnt <= '0;
          r_count    <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_count = r_count;
  assign bus.o_tick  = r_tick;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;

endmodule
